tmr_vote_register: RTL and testbench

TMR_VOTE_REGISTER -- requirements
Module: tmr_vote_register

---
 rtl/tmr_vote_register_if.sv | 30 +++
 rtl/tmr_vote_register.sv | 140 ++++++++++++++
 tb/tb_tmr_vote_register.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/tmr_vote_register_if.sv
// Bus bundle for the triplicated vote register: three input copies, load/clear
// controls, the three register copies, the voted output and the error monitor.
interface tmr_vote_register_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic [WIDTH-1:0] inC;
    logic             load;
    logic             clear;
    logic [WIDTH-1:0] outA;
    logic [WIDTH-1:0] outB;
    logic [WIDTH-1:0] outC;
    logic [WIDTH-1:0] out;
    logic             in_err;
    logic             reg_err;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       state;

    modport master (
        output inA, inB, inC, load, clear,
        input  outA, outB, outC, out, in_err, reg_err, err_count, state
    );

    modport slave (
        input  inA, inB, inC, load, clear,
        output outA, outB, outC, out, in_err, reg_err, err_count, state
    );
endinterface

// File: rtl/tmr_vote_register.sv
// Triple-modular-redundant register: votes inputs on load, scrubs copies otherwise, monitors faults.
// Latency: 1 cycle from load to out; out is the combinational vote of the register copies.
// Backpressure: none; load is accepted every cycle.
module tmr_vote_register #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 16,
    parameter int PERSIST = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    tmr_vote_register_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ERR  = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [WIDTH-1:0] a_d, b_d, c_d;
    logic             in_err_q, in_err_d;
    logic             reg_err_q, reg_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    state_e           state_q, state_d;
    logic [7:0]       ev_cnt_q, ev_cnt_d;
    logic [1:0]       clean_cnt_q, clean_cnt_d;

    logic [WIDTH-1:0] vin;
    logic [WIDTH-1:0] vreg;
    logic             in_mis;
    logic             reg_mis;
    logic             evt;
    logic [8:0]       ev_inc;

    assign vin     = (bus.inA & bus.inB) | (bus.inB & bus.inC) | (bus.inA & bus.inC);
    assign vreg    = (a_q & b_q) | (b_q & c_q) | (a_q & c_q);
    assign in_mis  = !((bus.inA == bus.inB) && (bus.inB == bus.inC));
    assign reg_mis = !((a_q == b_q) && (b_q == c_q));
    assign evt     = (bus.load && in_mis) || reg_mis;
    assign ev_inc  = {1'b0, ev_cnt_q} + 9'd1;

    always_comb begin
        a_d = bus.load ? vin : vreg;
        b_d = a_d;
        c_d = a_d;
        in_err_d  = bus.load && in_mis;
        reg_err_d = reg_mis;
        err_count_d = err_count_q;
        if (bus.clear) begin
            err_count_d = '0;
        end else if (evt && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // The event that moves OK->ERR is the first of the consecutive run, so the
    // run counter starts at 1 there; PERSIST back-to-back events reach FAIL.
    always_comb begin
        state_d     = state_q;
        ev_cnt_d    = ev_cnt_q;
        clean_cnt_d = clean_cnt_q;
        case (state_q)
            ST_OK: begin
                clean_cnt_d = 2'd0;
                if (evt) begin
                    state_d  = ST_ERR;
                    ev_cnt_d = 8'd1;
                end else begin
                    ev_cnt_d = 8'd0;
                end
            end
            ST_ERR: begin
                if (evt) begin
                    clean_cnt_d = 2'd0;
                    if (ev_inc >= 9'(PERSIST)) begin
                        state_d  = ST_FAIL;
                        ev_cnt_d = 8'd0;
                    end else begin
                        ev_cnt_d = ev_inc[7:0];
                    end
                end else begin
                    ev_cnt_d = 8'd0;
                    if (clean_cnt_q == 2'd3) begin
                        state_d     = ST_OK;
                        clean_cnt_d = 2'd0;
                    end else begin
                        clean_cnt_d = clean_cnt_q + 2'd1;
                    end
                end
            end
            ST_FAIL: begin
                ev_cnt_d    = 8'd0;
                clean_cnt_d = 2'd0;
                if (bus.clear) begin
                    state_d = ST_OK;
                end
            end
            default: begin
                state_d     = ST_OK;
                ev_cnt_d    = 8'd0;
                clean_cnt_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            in_err_q    <= 1'b0;
            reg_err_q   <= 1'b0;
            err_count_q <= '0;
            state_q     <= ST_OK;
            ev_cnt_q    <= 8'd0;
            clean_cnt_q <= 2'd0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            in_err_q    <= in_err_d;
            reg_err_q   <= reg_err_d;
            err_count_q <= err_count_d;
            state_q     <= state_d;
            ev_cnt_q    <= ev_cnt_d;
            clean_cnt_q <= clean_cnt_d;
        end
    end

    assign bus.outA      = a_q;
    assign bus.outB      = b_q;
    assign bus.outC      = c_q;
    assign bus.out       = vreg;
    assign bus.in_err    = in_err_q;
    assign bus.reg_err   = reg_err_q;
    assign bus.err_count = err_count_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_tmr_vote_register.sv
// Bench for tmr_vote_register: scenario tasks push expected results when driving
// stimulus and pop/compare them once the DUT has clocked.
module tb_tmr_vote_register;
    logic clk;
    logic rstn;

    tmr_vote_register_if #(.WIDTH(8), .CNT_W(16)) b0 ();
    tmr_vote_register_if #(.WIDTH(8), .CNT_W(2))  b1 ();

    tmr_vote_register #(.WIDTH(8), .CNT_W(16), .PERSIST(4)) dut0 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b0.slave)
    );

    tmr_vote_register #(.WIDTH(8), .CNT_W(2), .PERSIST(4)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b1.slave)
    );

    typedef struct packed {
        logic [7:0]  out;
        logic [7:0]  outb;
        logic        in_err;
        logic        reg_err;
        logic [15:0] cnt;
        logic [1:0]  st;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive0(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic ld, input logic clr);
        b0.inA = a; b0.inB = b; b0.inC = c; b0.load = ld; b0.clear = clr;
    endtask

    task automatic drive1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic ld, input logic clr);
        b1.inA = a; b1.inB = b; b1.inC = c; b1.load = ld; b1.clear = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rstn = (i == 2);
            drive0(8'h5A, 8'h5A, 8'h5A, (i != 2), (i == 1));
            sb.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 16'd0, 2'd0});
            tick();
            e = sb.pop_front();
            o = '{b0.out, b0.outB, b0.in_err, b0.reg_err, 16'(b0.err_count), b0.state};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset step=%0d got out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d exp out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d",
                         i, o.out, o.outb, o.in_err, o.reg_err, o.cnt, o.st, e.out, e.outb, e.in_err, e.reg_err, e.cnt, e.st);
            end
        end
    endtask

    task automatic test_clean_load();
        exp_t e, o;
        logic [7:0] dat [4] = '{8'h5A, 8'h3C, 8'h5A, 8'h00};
        logic       ld  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] ex  [4] = '{8'h5A, 8'h3C, 8'h5A, 8'h5A};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive0(dat[i], dat[i], dat[i], ld[i], 1'b0);
            sb.push_back('{ex[i], ex[i], 1'b0, 1'b0, 16'd0, 2'd0});
            tick();
            e = sb.pop_front();
            o = '{b0.out, b0.outB, b0.in_err, b0.reg_err, 16'(b0.err_count), b0.state};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL clean_load step=%0d got out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d exp out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d",
                         i, o.out, o.outb, o.in_err, o.reg_err, o.cnt, o.st, e.out, e.outb, e.in_err, e.reg_err, e.cnt, e.st);
            end
        end
    endtask

    task automatic test_input_upset();
        exp_t e, o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) drive0(8'h5A, 8'hFF, 8'h5A, 1'b1, 1'b0);
            else        drive0(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
            sb.push_back('{8'h5A, 8'h5A, (i == 0), 1'b0, 16'd1, (i == 4) ? 2'd0 : 2'd1});
            tick();
            e = sb.pop_front();
            o = '{b0.out, b0.outB, b0.in_err, b0.reg_err, 16'(b0.err_count), b0.state};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL input_upset step=%0d got out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d exp out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d",
                         i, o.out, o.outb, o.in_err, o.reg_err, o.cnt, o.st, e.out, e.outb, e.in_err, e.reg_err, e.cnt, e.st);
            end
        end
    endtask

    task automatic test_reg_upset();
        exp_t e, o;
        @(negedge clk);
        drive0(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        force dut0.b_q = 8'h00;
        sb.push_back('{8'h5A, 8'h00, 1'b0, 1'b0, 16'd1, 2'd0});
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                #3;
                release dut0.b_q;
                sb.push_back('{8'h5A, 8'h5A, 1'b0, 1'b1, 16'd2, 2'd1});
                tick();
            end else if (i > 1) begin
                @(negedge clk);
                sb.push_back('{8'h5A, 8'h5A, 1'b0, 1'b0, 16'd2, (i == 5) ? 2'd0 : 2'd1});
                tick();
            end
            e = sb.pop_front();
            o = '{b0.out, b0.outB, b0.in_err, b0.reg_err, 16'(b0.err_count), b0.state};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reg_upset step=%0d got out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d exp out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d",
                         i, o.out, o.outb, o.in_err, o.reg_err, o.cnt, o.st, e.out, e.outb, e.in_err, e.reg_err, e.cnt, e.st);
            end
        end
    endtask

    task automatic test_persist();
        exp_t e, o;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 4) begin
                drive0(8'h5A, 8'h00, 8'h5A, 1'b1, 1'b0);
                sb.push_back('{8'h5A, 8'h5A, 1'b1, 1'b0, 16'(3 + i), (i == 3) ? 2'd2 : 2'd1});
            end else if (i < 6) begin
                drive0(8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0);
                sb.push_back('{8'h5A, 8'h5A, 1'b0, 1'b0, 16'd6, 2'd2});
            end else begin
                drive0(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
                sb.push_back('{8'h5A, 8'h5A, 1'b0, 1'b0, 16'd0, 2'd0});
            end
            tick();
            e = sb.pop_front();
            o = '{b0.out, b0.outB, b0.in_err, b0.reg_err, 16'(b0.err_count), b0.state};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL persist step=%0d got out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d exp out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d",
                         i, o.out, o.outb, o.in_err, o.reg_err, o.cnt, o.st, e.out, e.outb, e.in_err, e.reg_err, e.cnt, e.st);
            end
        end
        @(negedge clk);
        drive0(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        exp_t e, o;
        logic [15:0] cnt [6] = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd0};
        logic [1:0]  st  [6] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive1(8'h5A, 8'hFF, 8'h5A, 1'b1, (i == 5));
            sb.push_back('{8'h5A, 8'h5A, 1'b1, 1'b0, cnt[i], st[i]});
            tick();
            e = sb.pop_front();
            o = '{b1.out, b1.outB, b1.in_err, b1.reg_err, 16'(b1.err_count), b1.state};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL saturation step=%0d got out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d exp out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d",
                         i, o.out, o.outb, o.in_err, o.reg_err, o.cnt, o.st, e.out, e.outb, e.in_err, e.reg_err, e.cnt, e.st);
            end
        end
        @(negedge clk);
        drive1(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        exp_t e, o;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rstn = (i != 2);
            if (i < 3) drive0(8'h5A, 8'h0F, 8'h5A, 1'b1, 1'b0);
            else       drive0(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
            if (i < 2) sb.push_back('{8'h5A, 8'h5A, 1'b1, 1'b0, 16'(i + 1), 2'd1});
            else       sb.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 16'd0, 2'd0});
            tick();
            e = sb.pop_front();
            o = '{b0.out, b0.outB, b0.in_err, b0.reg_err, 16'(b0.err_count), b0.state};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid_burst step=%0d got out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d exp out=%h outB=%h in_err=%b reg_err=%b cnt=%0d st=%0d",
                         i, o.out, o.outb, o.in_err, o.reg_err, o.cnt, o.st, e.out, e.outb, e.in_err, e.reg_err, e.cnt, e.st);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        drive0(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        drive1(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_clean_load();
        test_input_upset();
        test_reg_upset();
        test_persist();
        test_saturation();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
